// File: rtl/wb_port_arbiter.sv
// Purpose: shares the register-file write port between pipeline WB and a queued long-latency unit.
// Latency: WB grant -> rf_wr_* next cycle; LU push -> rf_wr_* two cycles later when the port is idle.
// Backpressure: lu_ready = !full (no path from the grant); wb_ready drops only on a forced FIFO grant.
// Optional build macro: WB_ARB_FAIRNESS_EN enables the starvation counter and forced FIFO grant.
module wb_port_arbiter #(
    parameter int DBITS        = 32,
    parameter int REGNOBITS    = 5,
    parameter int BUF_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wb_valid,
    input  logic [REGNOBITS-1:0]        wb_regno,
    input  logic [DBITS-1:0]            wb_data,
    output logic                        wb_ready,
    input  logic                        lu_valid,
    input  logic [REGNOBITS-1:0]        lu_regno,
    input  logic [DBITS-1:0]            lu_data,
    output logic                        lu_ready,
    output logic                        rf_wr_en,
    output logic [REGNOBITS-1:0]        rf_wr_regno,
    output logic [DBITS-1:0]            rf_wr_data,
    output logic [(2**REGNOBITS)-1:0]   lu_pending_mask
);
    localparam int IW = $clog2(BUF_DEPTH);
    localparam int PW = IW + 1;

    logic [REGNOBITS-1:0] buf_regno [BUF_DEPTH];
    logic [DBITS-1:0]     buf_data  [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] buf_vld;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [IW-1:0]        wr_idx;
    logic [IW-1:0]        rd_idx;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 grant_wb;
    logic                 force_grant;

    assign wr_idx   = wr_ptr[IW-1:0];
    assign rd_idx   = rd_ptr[IW-1:0];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_idx == rd_idx) && (wr_ptr[IW] != rd_ptr[IW]);
    assign lu_ready = !full;
    assign push     = lu_valid && !full;

`ifdef WB_ARB_FAIRNESS_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    assign force_grant = !empty && (starve_cnt == SW'(STARVE_LIMIT));
    assign wb_ready    = !force_grant;

    // Count cycles the head waits behind the pipeline; restart on every pop or when empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end
`else
    // Strict pipeline priority: no counter, so the limit has no consumer in this build.
    localparam int starve_limit_unused = STARVE_LIMIT;
    assign force_grant = 1'b0;
    assign wb_ready    = 1'b1;
`endif

    // The pipeline wins unless the head is being forced; otherwise an idle port drains the FIFO.
    assign grant_wb = wb_valid && !force_grant;
    assign pop      = !empty && !grant_wb;

    // Pointer and per-entry valid bookkeeping; push and pop never target the same slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            buf_vld <= '0;
        end else begin
            if (push) begin
                buf_vld[wr_idx] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                buf_vld[rd_idx] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
        end
    end

    // Payload storage needs no reset: a slot is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_regno[wr_idx] <= lu_regno;
            buf_data[wr_idx]  <= lu_data;
        end
    end

    // Registered write command; register 0 writes are consumed without asserting the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wr_en    <= 1'b0;
            rf_wr_regno <= '0;
            rf_wr_data  <= '0;
        end else if (grant_wb) begin
            rf_wr_en    <= (wb_regno != '0);
            rf_wr_regno <= wb_regno;
            rf_wr_data  <= wb_data;
        end else if (pop) begin
            rf_wr_en    <= (buf_regno[rd_idx] != '0);
            rf_wr_regno <= buf_regno[rd_idx];
            rf_wr_data  <= buf_data[rd_idx];
        end else begin
            rf_wr_en    <= 1'b0;
        end
    end

    // Destinations of every still-queued entry, so DE can interlock on them.
    always_comb begin
        lu_pending_mask = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (buf_vld[i]) begin
                lu_pending_mask[buf_regno[i]] = 1'b1;
            end
        end
        lu_pending_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_wb_port_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
`ifdef WB_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_regno;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        lu_valid;
    logic [4:0]  lu_regno;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_regno;
    logic [31:0] rf_wr_data;
    logic [31:0] lu_pending_mask;

    int tests  = 0;
    int failed = 0;
    bit chk_on = 1'b0;

    wb_port_arbiter #(
        .DBITS(32), .REGNOBITS(5), .BUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_regno(wb_regno), .wb_data(wb_data), .wb_ready(wb_ready),
        .lu_valid(lu_valid), .lu_regno(lu_regno), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_regno(rf_wr_regno), .rf_wr_data(rf_wr_data),
        .lu_pending_mask(lu_pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending results, a wait counter and the last write issued.
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;
    ent_t        mq[$];
    int          m_starve = 0;
    bit          m_en     = 1'b0;
    logic [4:0]  m_regno  = '0;
    logic [31:0] m_data   = '0;

    function automatic bit model_force();
        return FAIR && (mq.size() > 0) && (m_starve == LIMIT);
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].r] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    always @(posedge clk) begin : model
        bit   was_full;
        bit   nonempty;
        bit   popped;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_starve = 0;
            m_en     = 1'b0;
            m_regno  = '0;
            m_data   = '0;
        end else begin
            was_full = (mq.size() == DEPTH);
            nonempty = (mq.size() > 0);
            popped   = 1'b0;
            if (wb_valid && !model_force()) begin
                m_en    = (wb_regno != 0);
                m_regno = wb_regno;
                m_data  = wb_data;
            end else if (nonempty) begin
                e       = mq.pop_front();
                popped  = 1'b1;
                m_en    = (e.r != 0);
                m_regno = e.r;
                m_data  = e.d;
            end else begin
                m_en = 1'b0;
            end
            if (!nonempty || popped) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (lu_valid && !was_full) begin
                e.r = lu_regno;
                e.d = lu_data;
                mq.push_back(e);
            end
        end
    end

    // Compare the DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("lu_ready", {31'b0, lu_ready}, {31'b0, (mq.size() < DEPTH)});
            check("pending_mask", lu_pending_mask, model_mask());
            if (wb_valid) check("wb_ready", {31'b0, wb_ready}, {31'b0, !model_force()});
            check("rf_wr_en", {31'b0, rf_wr_en}, {31'b0, m_en});
            if (m_en) begin
                check("rf_wr_regno", {27'b0, rf_wr_regno}, {27'b0, m_regno});
                check("rf_wr_data", rf_wr_data, m_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wb_valid = 1'b0; wb_regno = '0; wb_data = '0;
        lu_valid = 1'b0; lu_regno = '0; lu_data = '0;
        cyc(); cyc();
        reset = 1'b0;
        chk_on = 1'b1;
        check("reset_en", {31'b0, rf_wr_en}, 32'd0);
        check("reset_lu_ready", {31'b0, lu_ready}, 32'd1);
        check("reset_mask", lu_pending_mask, 32'd0);

        // Pipeline-only writes, including a register-0 write.
        wb_valid = 1'b1; wb_regno = 5'd5; wb_data = 32'hDEADBEEF;
        check("wb_ready_p5", {31'b0, wb_ready}, 32'd1);
        cyc();
        check("wb_en_p5", {31'b0, rf_wr_en}, 32'd1);
        check("wb_regno_p5", {27'b0, rf_wr_regno}, 32'd5);
        check("wb_data_p5", rf_wr_data, 32'hDEADBEEF);
        wb_regno = 5'd0; wb_data = 32'h1234;
        check("wb_ready_r0", {31'b0, wb_ready}, 32'd1);
        cyc();
        check("wb_en_r0", {31'b0, rf_wr_en}, 32'd0);
        wb_valid = 1'b0;
        cyc();

        // LU result drains into an idle port.
        lu_valid = 1'b1; lu_regno = 5'd7; lu_data = 32'h12;
        cyc();
        lu_valid = 1'b0;
        check("lu_mask_set", lu_pending_mask, 32'h0000_0080);
        check("lu_en_early", {31'b0, rf_wr_en}, 32'd0);
        cyc();
        check("lu_en", {31'b0, rf_wr_en}, 32'd1);
        check("lu_regno", {27'b0, rf_wr_regno}, 32'd7);
        check("lu_data", rf_wr_data, 32'h12);
        check("lu_mask_clr", lu_pending_mask, 32'd0);
        cyc();

        // Fill the FIFO behind a busy pipeline, then drain in order.
        wb_valid = 1'b1; wb_regno = 5'd9;
        for (int i = 1; i <= 4; i++) begin
            wb_data = 32'h900 + i;
            lu_valid = 1'b1; lu_regno = 5'(i); lu_data = 32'(100 + i);
            cyc();
        end
        lu_valid = 1'b0;
        check("full_lu_ready", {31'b0, lu_ready}, 32'd0);
        check("full_mask", lu_pending_mask, 32'h0000_001E);
        wb_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("drain_en", {31'b0, rf_wr_en}, 32'd1);
            check("drain_regno", {27'b0, rf_wr_regno}, 32'(i));
            check("drain_data", rf_wr_data, 32'(100 + i));
            check("drain_lu_ready", {31'b0, lu_ready}, 32'd1);
        end
        cyc();
        check("drain_idle", {31'b0, rf_wr_en}, 32'd0);

        // One LU entry behind a pipeline that never idles.
        wb_valid = 1'b1; wb_regno = 5'd20; wb_data = 32'h0;
        lu_valid = 1'b1; lu_regno = 5'd11; lu_data = 32'hAB;
        cyc();
        lu_valid = 1'b0;
`ifdef WB_ARB_FAIRNESS_EN
        for (int k = 1; k <= 12; k++) begin
            wb_data = 32'hC0DE_0000 + k;
            check("fair_wb_ready", {31'b0, wb_ready}, (k == 9) ? 32'd0 : 32'd1);
            if (k == 10) begin
                check("fair_lu_regno", {27'b0, rf_wr_regno}, 32'd11);
                check("fair_lu_data", rf_wr_data, 32'hAB);
                check("fair_mask_clr", lu_pending_mask, 32'd0);
            end
            if (k == 11) begin
                check("fair_resume_regno", {27'b0, rf_wr_regno}, 32'd20);
                check("fair_resume_data", rf_wr_data, 32'hC0DE_000A);
            end
            cyc();
        end
        wb_valid = 1'b0;
        cyc();
`else
        for (int k = 1; k <= 50; k++) begin
            wb_data = 32'hC0DE_0000 + k;
            check("strict_wb_ready", {31'b0, wb_ready}, 32'd1);
            check("strict_mask", lu_pending_mask, 32'h0000_0800);
            check("strict_regno", {27'b0, rf_wr_regno}, 32'd20);
            cyc();
        end
        wb_valid = 1'b0;
        cyc();
        cyc();
        check("strict_late_regno", {27'b0, rf_wr_regno}, 32'd11);
        check("strict_late_data", rf_wr_data, 32'hAB);
`endif
        cyc();

        // Reset with three entries queued: nothing queued may ever be written.
        wb_valid = 1'b1; wb_regno = 5'd21; wb_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            lu_valid = 1'b1; lu_regno = 5'(12 + i); lu_data = 32'(32'h300 + i);
            cyc();
        end
        lu_valid = 1'b0;
        check("pre_reset_mask", lu_pending_mask, 32'h0000_7000);
        reset = 1'b1; wb_valid = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        check("post_reset_en", {31'b0, rf_wr_en}, 32'd0);
        check("post_reset_mask", lu_pending_mask, 32'd0);
        check("post_reset_lu_ready", {31'b0, lu_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("post_reset_idle", {31'b0, rf_wr_en}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline write-back (WB → DE path) and a long-latency execution unit (e.g. multiply/divide) that completes out of band. Long-latency results are queued in a small FIFO and drained into idle write-port cycles. A registered write command goes to the DE-stage register file. A per-register pending mask lets DE interlock on queued destinations.

## Interface
Parameters:
- DBITS, 32, data width
- REGNOBITS, 5, register index width (32 registers)
- BUF_DEPTH, 4, FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles a non-empty FIFO may wait before a forced grant (fairness build only)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  pipeline WB has a register write this cycle
- wb_regno  in  REGNOBITS  pipeline destination register
- wb_data  in  DBITS  pipeline write value
- wb_ready  out  1  pipeline write accepted this cycle; WB holds when low
- lu_valid  in  1  long-latency unit offers a result
- lu_regno  in  REGNOBITS  its destination register
- lu_data  in  DBITS  its value
- lu_ready  out  1  FIFO can accept (valid & ready = push)
- rf_wr_en  out  1  registered register-file write enable
- rf_wr_regno  out  REGNOBITS  registered write index
- rf_wr_data  out  DBITS  registered write value
- lu_pending_mask  out  2**REGNOBITS  bit r set while any valid FIFO entry targets r (bit 0 always 0)

## Operation
- FIFO: circular buffer. Read/write pointers are REGNOBITS-independent, $clog2(BUF_DEPTH)+1 bits, with wrap bit. Full = indices equal and wrap bits differ.
- lu_ready = !full. It does not depend on a same-cycle pop, so there is no combinational path from the grant to lu_ready.
- Grant per cycle, exactly one source at most:
  - force = FIFO non-empty & starve_cnt == STARVE_LIMIT (fairness build only, else 0)
  - force: grant FIFO head, wb_ready = 0
  - else wb_valid: grant pipeline, wb_ready = 1
  - else FIFO non-empty: grant head (pop)
  - else idle
- wb_ready = !force. When wb_valid is low, wb_ready's value is don't-care.
- Granted write goes to the output register next edge. Writes with regno 0 are consumed (popped/acknowledged) but drive rf_wr_en = 0.
- No ordering between sources. DE must stall any instruction whose destination or source hits lu_pending_mask, which guarantees no WAW/RAW across sources.
- lu_pending_mask is combinational from FIFO valid entries. An entry's bit clears the cycle after its pop, coincident with rf_wr_en for that write.

## Timing
- Reset (synchronous): FIFO empty (pointers 0), rf_wr_en/regno/data = 0, starve_cnt = 0, lu_pending_mask = 0, lu_ready = 1. Reset mid-operation discards all queued entries; no write is issued on the cycle after reset.
- Pipeline latency: granted at cycle N → rf_wr_* valid in cycle N+1 (one cycle).
- LU latency, FIFO empty and WB idle: pushed at edge N → head visible cycle N+1, granted → rf_wr_en in cycle N+2.
- Simultaneous push and pop: allowed when not full; occupancy is unchanged.
- Push to full FIFO: impossible (lu_ready = 0). Pop from empty: never.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - clears to 0 when FIFO is empty or the head is popped
  - else increments each cycle the head is not granted, saturating at STARVE_LIMIT

## Configuration
- WB_ARB_FAIRNESS_EN defined: starvation counter and forced grant as above. In a forced cycle wb_ready = 0 for one cycle.
- Not defined: strict pipeline priority. wb_ready is tied to 1, starve_cnt is not instantiated, and the FIFO drains only in cycles with wb_valid = 0 (unbounded wait permitted).

## Test plan
- Reset/idle: assert reset 2 cycles mid-traffic with 3 entries queued → next cycle rf_wr_en = 0, lu_pending_mask = 0, lu_ready = 1; queued data never written.
- Pipeline only: wb_valid with regno 5, data 0xDEADBEEF at cycle N → rf_wr_en = 1, regno 5, data 0xDEADBEEF in N+1; regno 0 → rf_wr_en = 0, wb_ready = 1.
- LU drain in idle: lu push regno 7, data 0x12 with WB idle → lu_pending_mask[7] = 1 for one cycle, rf_wr_en regno 7 two cycles after push, mask bit 7 clears same cycle.
- Full FIFO: wb_valid held high, push 4 LU results (regnos 1–4) → lu_ready = 0 after 4th push. Drop wb_valid → writes 1,2,3,4 in order on consecutive cycles; lu_ready = 1 the cycle after the first pop.
- Fairness (macro on, STARVE_LIMIT 8): wb_valid held high, one LU entry queued → wb_ready = 0 exactly once, on the 9th cycle the entry is queued; LU write appears the next cycle; pipeline resumes.
- Fairness off: same stimulus for 50 cycles → wb_ready always 1, LU entry never written, lu_pending_mask bit held.
